// File: rtl/axi4l_sram_slave.sv
// AXI4-Lite single-port SRAM slave with byte-strobed writes and configurable read latency.
// Optional macro OOR_SLVERR_EN: out-of-range accesses get SLVERR; otherwise the index wraps (DEPTH must be a power of two).
module axi4l_sram_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                RD_LAT    = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                arvalid,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                arready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  input  logic                rready,
  input  logic                awvalid,
  input  logic [ADDR_W-1:0]   awaddr,
  output logic                awready,
  input  logic                wvalid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                wready,
  output logic                bvalid,
  output logic [1:0]          bresp,
  input  logic                bready
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_LAT    = 2'd1;
  localparam logic [1:0] R_RESP   = 2'd2;
  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_RESP   = 2'd2;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    word_idx = IDX_W'(off >> OFS_W);
  endfunction

`ifdef OOR_SLVERR_EN
  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    out_of_range = (addr < BASE_ADDR) || ((off >> OFS_W) >= ADDR_W'(DEPTH));
  endfunction
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        rstate;
  logic [3:0]        rcnt;
  logic [IDX_W-1:0]  ar_idx;
  logic              ar_err;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_err;
  logic              ar_hs;

  logic [1:0]        wstate;
  logic              aw_held;
  logic              w_held;
  logic              aw_got;
  logic              w_got;
  logic              aw_err;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_err;
  logic [DATA_W-1:0] wr_data;
  logic [LANES-1:0]  wr_strb;
  logic              aw_hs;
  logic              w_hs;

  assign ar_idx = word_idx(araddr);
`ifdef OOR_SLVERR_EN
  assign ar_err = out_of_range(araddr);
  assign aw_err = out_of_range(awaddr);
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  assign arready = !RST && (rstate == R_IDLE);
  assign awready = !RST && (wstate == W_IDLE) && !aw_held;
  assign wready  = !RST && (wstate == W_IDLE) && !w_held;

  assign ar_hs  = arvalid && arready;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign aw_got = aw_held || aw_hs;
  assign w_got  = w_held || w_hs;

  // Captured address/data payloads carry no reset; the FSM flags qualify them.
  always_ff @(posedge CLK) begin
    if (ar_hs) begin
      rd_idx <= ar_idx;
      rd_err <= ar_err;
    end
    if (aw_hs) begin
      wr_idx <= word_idx(awaddr);
      wr_err <= aw_err;
    end
    if (w_hs) begin
      wr_data <= wdata;
      wr_strb <= wstrb;
    end
  end

  // Read FSM. The word is sampled on the edge where the latency count expires;
  // with RD_LAT=1 that is the AR handshake edge itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rstate <= R_IDLE;
      rcnt   <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rcnt <= 4'(RD_LAT - 1);
            if (RD_LAT == 1) begin
              rdata  <= ar_err ? '0 : mem[ar_idx];
              rresp  <= ar_err ? 2'b10 : 2'b00;
              rvalid <= 1'b1;
              rstate <= R_RESP;
            end else begin
              rstate <= R_LAT;
            end
          end
        end
        R_LAT: begin
          rcnt <= rcnt - 4'd1;
          if (rcnt == 4'd1) begin
            rdata  <= rd_err ? '0 : mem[rd_idx];
            rresp  <= rd_err ? 2'b10 : 2'b00;
            rvalid <= 1'b1;
            rstate <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW and W are collected independently, then committed together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wstate  <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_got && w_got) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wstate  <= W_COMMIT;
          end else begin
            aw_held <= aw_got;
            w_held  <= w_got;
          end
        end
        W_COMMIT: begin
          bvalid <= 1'b1;
          bresp  <= wr_err ? 2'b10 : 2'b00;
          wstate <= W_RESP;
        end
        W_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Non-blocking update keeps a same-edge read sample on the old word.
  always_ff @(posedge CLK) begin
    if (wstate == W_COMMIT && !wr_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4l_sram_slave.sv
// Self-checking bench for axi4l_sram_slave: directed scenarios plus randomized traffic against a word-array model.
// Honours OOR_SLVERR_EN the same way the design does.
module tb_axi4l_sram_slave;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 64;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 1;
  localparam logic [31:0] BASE   = 32'h8000_0000;
`ifdef OOR_SLVERR_EN
  localparam bit SLVERR = 1'b1;
`else
  localparam bit SLVERR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] model [DEPTH];

  axi4l_sram_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  always #5 CLK = ~CLK;

  function automatic bit in_range(input logic [31:0] a);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return (off >= 0) && ((off / 8) < DEPTH);
  endfunction

  // Out-of-range addresses alias modulo the 32-bit address space and then modulo DEPTH.
  function automatic int model_idx(input logic [31:0] a);
    longint off;
    off = (longint'({32'd0, a}) - longint'({32'd0, BASE})) & 64'h0000_0000_FFFF_FFFF;
    return int'((off / 8) % DEPTH);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int order, input int gap, input int bdelay, input string tag);
    bit aw_done, w_done, hs_aw, hs_w, ok, stable;
    int cyc, idx;
    logic [1:0] exp_r;
    aw_done = 0; w_done = 0; ok = 1; cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && (order != 1 || cyc >= gap);
      wvalid  = !w_done  && (order != 2 || cyc >= gap);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if ((aw_done && awready) || (w_done && wready)) ok = 0;
      @(posedge CLK); #1;
      aw_done |= hs_aw;
      w_done  |= hs_w;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    n_checks++;
    if (!(aw_done && w_done)) begin
      $display("FAIL %s handshake_timeout aw=%0b w=%0b expected both accepted", tag, aw_done, w_done);
      return;
    end else n_pass++;
    n_checks++;
    if (!ok) $display("FAIL %s ready_after_capture ready stayed high after channel accepted, expected 0", tag);
    else n_pass++;
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0)
      $display("FAIL %s commit_cycle bvalid=%b awready=%b wready=%b expected 0 0 0", tag, bvalid, awready, wready);
    else n_pass++;
    @(posedge CLK); #1;
    exp_r = (SLVERR && !in_range(a)) ? 2'b10 : 2'b00;
    if (!(SLVERR && !in_range(a))) begin
      idx = model_idx(a);
      for (int i = 0; i < 8; i++) if (s[i]) model[idx][i*8 +: 8] = d[i*8 +: 8];
    end
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== exp_r)
      $display("FAIL %s bresp bvalid=%b bresp=%b expected 1 %b", tag, bvalid, bresp, exp_r);
    else n_pass++;
    bready = 0; stable = 1;
    for (int i = 0; i < bdelay; i++) begin
      @(posedge CLK); #1;
      if (bvalid !== 1'b1 || bresp !== exp_r || awready !== 1'b0 || wready !== 1'b0) stable = 0;
    end
    n_checks++;
    if (!stable) $display("FAIL %s b_backpressure response or readies changed while bready=0, expected held", tag);
    else n_pass++;
    bready = 1;
    @(posedge CLK); #1;
    bready = 0;
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1)
      $display("FAIL %s b_release bvalid=%b awready=%b wready=%b expected 0 1 1", tag, bvalid, awready, wready);
    else n_pass++;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdelay, input string tag);
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    int cyc;
    bit stable;
    if (SLVERR && !in_range(a)) begin
      exp_d = 64'd0; exp_r = 2'b10;
    end else begin
      exp_d = model[model_idx(a)]; exp_r = 2'b00;
    end
    araddr = a; arvalid = 1; cyc = 0;
    while (!arready && cyc < 50) begin
      @(posedge CLK); #1; cyc++;
    end
    n_checks++;
    if (!arready) begin
      $display("FAIL %s arready_timeout arready=%b expected 1", tag, arready);
      arvalid = 0;
      return;
    end else n_pass++;
    @(posedge CLK); #1;
    arvalid = 0;
    for (int i = 1; i < RD_LAT; i++) begin
      @(posedge CLK); #1;
    end
    n_checks++;
    if (rvalid !== 1'b1 || arready !== 1'b0)
      $display("FAIL %s rvalid_latency rvalid=%b arready=%b expected 1 0", tag, rvalid, arready);
    else n_pass++;
    n_checks++;
    if (rdata !== exp_d || rresp !== exp_r)
      $display("FAIL %s rdata got %h/%b expected %h/%b", tag, rdata, rresp, exp_d, exp_r);
    else n_pass++;
    rready = 0; stable = 1;
    for (int i = 0; i < rdelay; i++) begin
      @(posedge CLK); #1;
      if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_r || arready !== 1'b0) stable = 0;
    end
    n_checks++;
    if (!stable) $display("FAIL %s r_backpressure read response changed while rready=0, expected held", tag);
    else n_pass++;
    rready = 1;
    @(posedge CLK); #1;
    rready = 0;
    n_checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1)
      $display("FAIL %s r_release rvalid=%b arready=%b expected 0 1", tag, rvalid, arready);
    else n_pass++;
  endtask

  task automatic test_reset;
    RST = 1;
    arvalid = 0; araddr = '0; rready = 0;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b0 || rdata !== 64'd0 || rresp !== 2'b00 || bresp !== 2'b00)
        $display("FAIL reset_hold ar/aw/w/rv/bv=%b%b%b%b%b rdata=%h expected all 0",
                 arready, awready, wready, rvalid, bvalid, rdata);
      else n_pass++;
    end
    RST = 0; #1;
    n_checks++;
    if ({arready, awready, wready} !== 3'b111)
      $display("FAIL reset_release readies=%b expected 111", {arready, awready, wready});
    else n_pass++;
  endtask

  task automatic test_write_read;
    do_write(BASE + 32'h8, 64'h1122334455667788, 8'hFF, 0, 0, 0, "wr_basic");
    do_read(BASE + 32'h8, 0, "rd_basic");
  endtask

  task automatic test_strobes;
    do_write(BASE + 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0, 0, "wr_strb");
    n_checks++;
    if (model[1] !== 64'h11223344FFFFFFFF)
      $display("FAIL strb_model got %h expected 11223344ffffffff", model[1]);
    else n_pass++;
    do_read(BASE + 32'h8, 0, "rd_strb");
    do_write(BASE + 32'h8, 64'h0, 8'h00, 0, 0, 0, "wr_nostrb");
    do_read(BASE + 32'h8, 0, "rd_nostrb");
  endtask

  task automatic test_backpressure;
    do_read(BASE + 32'h8, 5, "rd_bp");
    do_write(BASE + 32'h10, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 0, 5, "wr_bp");
  endtask

  task automatic test_ordering;
    do_write(BASE + 32'h18, 64'hA5A5_0000_5A5A_1111, 8'hFF, 1, 3, 0, "wr_w_first");
    do_read(BASE + 32'h18, 0, "rd_w_first");
    do_write(BASE + 32'h20, 64'h0123_4567_89AB_CDEF, 8'hFF, 2, 3, 0, "wr_aw_first");
    do_read(BASE + 32'h20, 0, "rd_aw_first");
  endtask

  task automatic test_out_of_range;
    do_write(BASE + 32'h7FF8, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0, 0, "wr_top_word");
    do_read(32'h7FFF_FFF8, 0, "rd_oor");
    do_write(32'h7FFF_FFF8, 64'h5555_6666_7777_8888, 8'hFF, 0, 0, 0, "wr_oor");
    do_read(BASE + 32'h7FF8, 0, "rd_top_after_oor");
  endtask

  task automatic test_read_before_write;
    logic [31:0] a;
    logic [63:0] old_d;
    a = BASE + 32'd160;
    do_write(a, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 0, 0, 0, "rbw_init");
    old_d = model[model_idx(a)];
    awaddr = a; wdata = 64'h600D_600D_600D_600D; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
    @(posedge CLK); #1;
    awvalid = 0; wvalid = 0; araddr = a; arvalid = 1;
    @(posedge CLK); #1;
    arvalid = 0;
    model[model_idx(a)] = 64'h600D_600D_600D_600D;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== old_d || bvalid !== 1'b1)
      $display("FAIL rbw_same_cycle rvalid=%b rdata=%h bvalid=%b expected 1 %h 1", rvalid, rdata, bvalid, old_d);
    else n_pass++;
    rready = 1; bready = 1;
    @(posedge CLK); #1;
    rready = 0; bready = 0;
    do_read(a, 0, "rbw_new");
  endtask

  task automatic test_reset_mid;
    bit quiet;
    araddr = BASE; arvalid = 1;
    @(posedge CLK); #1;
    arvalid = 0;
    #2 RST = 1;
    #1;
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 64'd0 || {arready, awready, wready} !== 3'b000)
      $display("FAIL reset_mid rvalid=%b rdata=%h readies=%b expected 0 0 000",
               rvalid, rdata, {arready, awready, wready});
    else n_pass++;
    @(posedge CLK); #1;
    RST = 0;
    rready = 1; quiet = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (rvalid !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b1) quiet = 0;
    end
    rready = 0;
    n_checks++;
    if (!quiet) $display("FAIL reset_mid_quiet a response appeared after reset, expected none");
    else n_pass++;
  endtask

  task automatic test_random;
    int idx_set [17];
    int k, idx;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) idx_set[i] = i;
    idx_set[16] = DEPTH - 1;
    for (int i = 0; i < 17; i++)
      do_write(BASE + 32'(idx_set[i] * 8), {$urandom, $urandom}, 8'hFF, 0, 0, 0, "rnd_init");
    for (int n = 0; n < 40; n++) begin
      k   = $urandom_range(0, 16);
      idx = idx_set[k];
      if ($urandom_range(0, 7) == 0) a = BASE + 32'((DEPTH + idx) * 8);
      else                           a = BASE + 32'(idx * 8);
      a[2:0] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        do_write(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2), $urandom_range(1, 3),
                 $urandom_range(0, 3), "rnd_wr");
      else
        do_read(a, $urandom_range(0, 3), "rnd_rd");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_read;
    test_strobes;
    test_backpressure;
    test_ordering;
    test_out_of_range;
    test_read_before_write;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
